// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Port ids double as the tag stored per outstanding request.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        PortI = 1'b0,
        PortD = 1'b1
    } port_e;

    localparam int unsigned NumPorts = 2;

    function automatic port_e other_port(input port_e p);
        return (p == PortI) ? PortD : PortI;
    endfunction

endpackage

// File: rtl/mem_arbiter_fifo.sv
// Small synchronous FIFO with a ready/valid write side and a ready/valid read side.
// A read in the same cycle does not free a slot for a write when full.
module mem_arbiter_fifo #(
    parameter int unsigned Width     = 1,
    parameter int unsigned DepthLog2 = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [Width-1:0] wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [Width-1:0] rd_data_o
);

    localparam int unsigned Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0] DepthCnt = (DepthLog2 + 1)'(Depth);

    logic [Width-1:0]     mem_q [Depth];
    logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthLog2:0]   count_q, count_d;
    logic                 push, pop;

    assign wr_ready_o = (count_q != DepthCnt);
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];

    assign push = wr_valid_i & wr_ready_o;
    assign pop  = rd_ready_i & rd_valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries counted by count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// 2:1 arbiter merging instruction-fetch and data ports onto one in-order memory port.
// Build option MEM_ARB_RR_EN: round-robin between ports instead of data-port priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DepthLog2 = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    output logic        i_ready_o,
    input  logic        i_valid_i,
    input  logic [31:0] i_addr_i,
    input  logic [31:0] i_wdata_i,
    input  logic [3:0]  i_wmask_i,
    output logic [31:0] i_rdata_o,
    output logic        i_rvalid_o,

    output logic        d_ready_o,
    input  logic        d_valid_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wmask_i,
    output logic [31:0] d_rdata_o,
    output logic        d_rvalid_o,

    input  logic        mem_ready_i,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i
);

    port_e      grant;
    port_e      lock_grant_q, lock_grant_d;
    logic       lock_q, lock_d;
    logic       tag_wr_ready, tag_full;
    logic       tag_rd_valid;
    logic [0:0] tag_rd_data;
    port_e      tag_head;
    logic       mem_fire, rsp_fire;

`ifdef MEM_ARB_RR_EN
    port_e      last_grant_q, last_grant_d;
`endif

    assign tag_full = ~tag_wr_ready;

    always_comb begin
        grant = PortI;
        if (lock_q) begin
            grant = lock_grant_q;
        end else if (i_valid_i && d_valid_i) begin
`ifdef MEM_ARB_RR_EN
            grant = other_port(last_grant_q);
`else
            // Data wins so a core stalled on a load/store cannot be starved by fetch.
            grant = PortD;
`endif
        end else if (d_valid_i) begin
            grant = PortD;
        end
    end

    assign mem_valid_o = (i_valid_i | d_valid_i) & ~tag_full;
    assign mem_addr_o  = (grant == PortD) ? d_addr_i  : i_addr_i;
    assign mem_wdata_o = (grant == PortD) ? d_wdata_i : i_wdata_i;
    assign mem_wmask_o = (grant == PortD) ? d_wmask_i : i_wmask_i;

    assign i_ready_o = mem_ready_i & ~tag_full & (grant == PortI);
    assign d_ready_o = mem_ready_i & ~tag_full & (grant == PortD);

    assign mem_fire = mem_valid_o & mem_ready_i;

    // A request presented but not taken keeps its grant next cycle so the
    // memory side never sees the request change underneath it.
    always_comb begin
        lock_d       = mem_valid_o & ~mem_ready_i;
        lock_grant_d = grant;
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (mem_fire) begin
            last_grant_d = grant;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_grant_q <= PortI;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= PortI;
`endif
        end else begin
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    mem_arbiter_fifo #(
        .Width     (1),
        .DepthLog2 (DepthLog2)
    ) u_tag_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_valid_i (mem_fire),
        .wr_ready_o (tag_wr_ready),
        .wr_data_i  (grant),
        .rd_valid_o (tag_rd_valid),
        .rd_ready_i (mem_rvalid_i),
        .rd_data_o  (tag_rd_data)
    );

    assign tag_head = port_e'(tag_rd_data);

    // Responses with no outstanding tag (e.g. issued before a reset) are dropped.
    assign rsp_fire   = mem_rvalid_i & tag_rd_valid;
    assign i_rvalid_o = rsp_fire & (tag_head == PortI);
    assign d_rvalid_o = rsp_fire & (tag_head == PortD);
    assign i_rdata_o  = mem_rdata_i;
    assign d_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: port handshakes push expected responses,
// a latency-1 memory model answers from the granted address.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_ready_o, i_valid_i, i_rvalid_o;
    logic [31:0] i_addr_i, i_wdata_i, i_rdata_o;
    logic [3:0]  i_wmask_i;
    logic        d_ready_o, d_valid_i, d_rvalid_o;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [3:0]  d_wmask_i;
    logic        mem_ready_i, mem_valid_o, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wmask_o;

    typedef struct {
        logic        port_d;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    int          checks = 0;
    int          errors = 0;
    int          mem_xfers = 0;
    bit          auto_rsp = 1'b1;
    bit          force_rsp = 1'b0;
    bit          persist = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.DepthLog2(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_ready_o    (i_ready_o),
        .i_valid_i    (i_valid_i),
        .i_addr_i     (i_addr_i),
        .i_wdata_i    (i_wdata_i),
        .i_wmask_i    (i_wmask_i),
        .i_rdata_o    (i_rdata_o),
        .i_rvalid_o   (i_rvalid_o),
        .d_ready_o    (d_ready_o),
        .d_valid_i    (d_valid_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_wmask_i    (d_wmask_i),
        .d_rdata_o    (d_rdata_o),
        .d_rvalid_o   (d_rvalid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_valid_o  (mem_valid_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i)
    );

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic begin_cycle();
        if ((auto_rsp || force_rsp) && pend_q.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend_q.pop_front();
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic end_cycle();
        exp_t e;
        logic hs_i, hs_d;
        if (mem_rvalid_i && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("i_rvalid", 32'(i_rvalid_o), 32'(!e.port_d));
            check("d_rvalid", 32'(d_rvalid_o), 32'(e.port_d));
            if (e.port_d) check("d_rdata", d_rdata_o, e.data);
            else          check("i_rdata", i_rdata_o, e.data);
        end else begin
            check("i_rvalid_idle", 32'(i_rvalid_o), 32'd0);
            check("d_rvalid_idle", 32'(d_rvalid_o), 32'd0);
        end
        if (mem_valid_o && mem_ready_i) begin
            pend_q.push_back(rsp_of(mem_addr_o));
            mem_xfers++;
        end
        hs_i = i_valid_i && i_ready_o;
        hs_d = d_valid_i && d_ready_o;
        if (hs_i) exp_q.push_back('{port_d: 1'b0, data: rsp_of(i_addr_i)});
        if (hs_d) exp_q.push_back('{port_d: 1'b1, data: rsp_of(d_addr_i)});
        @(posedge clk_i);
        @(negedge clk_i);
        if (hs_i) begin
            if (persist) i_addr_i = i_addr_i + 32'd4;
            else         i_valid_i = 1'b0;
        end
        if (hs_d) begin
            if (persist) d_addr_i = d_addr_i + 32'd4;
            else         d_valid_i = 1'b0;
        end
    endtask

    task automatic cycle();
        begin_cycle();
        end_cycle();
    endtask

    task automatic wait_accept();
        int n = 0;
        while ((i_valid_i || d_valid_i) && n < 20) begin
            cycle();
            n++;
        end
        check("accept_timeout", 32'(i_valid_i | d_valid_i), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        auto_rsp = 1'b1;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 30) begin
            cycle();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_i(input logic [31:0] a);
        i_valid_i = 1'b1;
        i_addr_i  = a;
        wait_accept();
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        i_valid_i    = 1'b0;
        d_valid_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int x0;
        logic expd;
        rst_i = 1'b1;
        i_valid_i = 1'b0; i_addr_i = '0; i_wdata_i = '0; i_wmask_i = '0;
        d_valid_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wmask_i = '0;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        begin_cycle();
        check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
        end_cycle();

        // Fetch-only stream
        x0 = mem_xfers;
        send_i(32'h0);
        send_i(32'h4);
        send_i(32'h8);
        drain();
        check("fetch_xfers", 32'(mem_xfers - x0), 32'd3);

        // Both valid together: data first, then fetch
        i_valid_i = 1'b1; i_addr_i = 32'h10; i_wmask_i = 4'h0;
        d_valid_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'h1234_5678; d_wmask_i = 4'hF;
        begin_cycle();
        check("both_first_addr", mem_addr_o, 32'h100);
        check("both_first_wmask", 32'(mem_wmask_o), 32'hF);
        check("both_first_wdata", mem_wdata_o, 32'h1234_5678);
        end_cycle();
        begin_cycle();
        check("both_second_addr", mem_addr_o, 32'h10);
        check("both_second_wmask", 32'(mem_wmask_o), 32'h0);
        end_cycle();
        wait_accept();
        drain();
        d_wmask_i = 4'h0;

        // Grant lock while memory stalls
        mem_ready_i = 1'b0;
        i_valid_i = 1'b1; i_addr_i = 32'h10;
        begin_cycle();
        check("lock_c1_addr", mem_addr_o, 32'h10);
        end_cycle();
        d_valid_i = 1'b1; d_addr_i = 32'h100;
        begin_cycle();
        check("lock_c2_addr", mem_addr_o, 32'h10);
        check("lock_c2_dready", 32'(d_ready_o), 32'd0);
        end_cycle();
        begin_cycle();
        check("lock_c3_addr", mem_addr_o, 32'h10);
        end_cycle();
        mem_ready_i = 1'b1;
        begin_cycle();
        check("lock_acc_addr", mem_addr_o, 32'h10);
        check("lock_acc_iready", 32'(i_ready_o), 32'd1);
        end_cycle();
        begin_cycle();
        check("lock_then_d", mem_addr_o, 32'h100);
        end_cycle();
        wait_accept();
        drain();

        // Tag FIFO full: fifth request held, pop does not bypass
        auto_rsp = 1'b0;
        for (int k = 0; k < 4; k++) send_i(32'h40 + 32'(k * 4));
        i_valid_i = 1'b1; i_addr_i = 32'h50;
        begin_cycle();
        check("full_mem_valid", 32'(mem_valid_o), 32'd0);
        check("full_iready", 32'(i_ready_o), 32'd0);
        end_cycle();
        force_rsp = 1'b1;
        begin_cycle();
        force_rsp = 1'b0;
        check("full_pop_no_bypass", 32'(mem_valid_o), 32'd0);
        end_cycle();
        begin_cycle();
        check("full_after_pop_valid", 32'(mem_valid_o), 32'd1);
        check("full_after_pop_addr", mem_addr_o, 32'h50);
        end_cycle();
        drain();

        // Both continuously valid: priority or alternation from a fresh reset
        do_reset();
        persist = 1'b1;
        i_valid_i = 1'b1; i_addr_i = 32'h1000;
        d_valid_i = 1'b1; d_addr_i = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            expd = RrEn ? ((k % 2) == 0) : 1'b1;
            begin_cycle();
            check("grant_d", 32'(d_ready_o), 32'(expd));
            check("grant_i", 32'(i_ready_o), 32'(!expd));
            end_cycle();
        end
        persist = 1'b0;
        i_valid_i = 1'b0;
        d_valid_i = 1'b0;
        drain();

        // Reset with two outstanding: late responses dropped
        auto_rsp = 1'b0;
        send_i(32'h300);
        send_i(32'h304);
        do_reset();
        check("rst_pending_mem", 32'(pend_q.size()), 32'd2);
        force_rsp = 1'b1;
        cycle();
        cycle();
        force_rsp = 1'b0;
        auto_rsp = 1'b1;
        send_i(32'h200);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
